// File: rtl/mips_pkg.sv
// Shared fetch-side definitions for the 3-stage MIPS pipe: PC source codes,
// the NOP encoding, the fetch FSM states and a saturating counter helper.
package mips_pkg;

  localparam logic [1:0]  PCSRC_SEQ = 2'b00;
  localparam logic [1:0]  PCSRC_BR  = 2'b01;
  localparam logic [1:0]  PCSRC_J   = 2'b10;
  localparam logic [1:0]  PCSRC_JR  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target generation for branch, jump and JR, plus
// detection of a JR target that is not word aligned.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        pcsrc,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [15:0]       imm,
  input  logic [25:0]       jindex,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  logic [ADDR_W-1:0] br_off;

  always_comb begin
    br_off     = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    target     = pc_plus4;
    misaligned = 1'b0;
    case (pcsrc)
      PCSRC_BR: target = pc_plus4 + br_off;
      PCSRC_J:  target = {pc_plus4[ADDR_W-1:28], jindex, 2'b00};
      PCSRC_JR: begin
        // The low bits are dropped so fetch stays aligned; the flag records it.
        target     = {jr_target[ADDR_W-1:2], 2'b00};
        misaligned = |jr_target[1:0];
      end
      default:  target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Owns the PC and the IF->EX instruction register, redirects fetch on taken
// control transfers from EX and inserts bubbles behind each redirect.
module fetch_redirect_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                BUBBLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pcsrc_EX,
  input  logic              stall_EX,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc_plus4,
  input  logic [15:0]       ex_imm,
  input  logic [25:0]       ex_jindex,
  input  logic [ADDR_W-1:0] ex_jr_target,
  input  logic              hold,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic              flush,
  output logic              ctrl_err,
  output logic              misalign,
  output logic [15:0]       redirect_cnt
);

  localparam logic [1:0] BUBBLE_INIT = 2'(BUBBLES - 1);

  fetch_state_e      state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;
  logic              tgt_misaligned;
  logic              ctrl_bad;
  logic              accept;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pcsrc      (pcsrc_EX),
    .pc_plus4   (ex_pc_plus4),
    .imm        (ex_imm),
    .jindex     (ex_jindex),
    .jr_target  (ex_jr_target),
    .target     (target),
    .misaligned (tgt_misaligned)
  );

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // A legal pair has stall_EX set exactly when pcsrc_EX requests a redirect.
  assign ctrl_bad = ex_valid &
                    ((stall_EX != (pcsrc_EX != PCSRC_SEQ)) | $isunknown({pcsrc_EX, stall_EX}));
  assign accept   = ex_valid & stall_EX & (pcsrc_EX != PCSRC_SEQ) & ~ctrl_bad &
                    (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    pc_d     = pc_q;
    id_pc4_d = id_pc4_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    flush_d  = 1'b0;
    err_d    = err_q | ctrl_bad;
    mis_d    = mis_q;
    cnt_d    = cnt_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          pc_d    = target;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          flush_d = 1'b1;
          cnt_d   = sat_inc16(cnt_q);
          mis_d   = mis_q | tgt_misaligned;
          state_d = BUBBLE;
          bcnt_d  = BUBBLE_INIT;
        end else if (!hold) begin
          pc_d     = pc_plus4;
          instr_d  = imem_rdata;
          id_pc4_d = pc_plus4;
          valid_d  = 1'b1;
        end
      end
      BUBBLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (bcnt_q == 2'd0) state_d = RUN;
        else                bcnt_d  = bcnt_q - 2'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      bcnt_q   <= 2'd0;
      pc_q     <= RESET_PC;
      id_pc4_q <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      pc_q     <= pc_d;
      id_pc4_q <= id_pc4_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_instr     = instr_q;
  assign id_pc_plus4  = id_pc4_q;
  assign id_valid     = valid_q;
  assign flush        = flush_q;
  assign ctrl_err     = err_q;
  assign misalign     = mis_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed vector table, hand-written reset and
// wrap sequences, then randomized traffic against a behavioural model.
module tb_fetch_redirect_unit;

  localparam int BUBBLES = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pcsrc_EX;
  logic        stall_EX, ex_valid, hold;
  logic [31:0] ex_pc_plus4, ex_jr_target, imem_rdata, imem_addr, id_instr, id_pc_plus4;
  logic [15:0] ex_imm, redirect_cnt;
  logic [25:0] ex_jindex;
  logic        id_valid, flush, ctrl_err, misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fetch_redirect_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BUBBLES(BUBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .pcsrc_EX(pcsrc_EX), .stall_EX(stall_EX),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_imm(ex_imm),
    .ex_jindex(ex_jindex), .ex_jr_target(ex_jr_target), .hold(hold),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .flush(flush),
    .ctrl_err(ctrl_err), .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  // Behavioural model: remaining-NOP countdown instead of an explicit FSM.
  logic [31:0] m_pc, m_instr, m_pp4;
  bit          m_valid, m_flush, m_err, m_mis;
  int          m_cnt, m_left;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_flush = 0;
    m_err = 0; m_mis = 0; m_cnt = 0; m_left = 0;
  endtask

  task automatic model_step();
    bit          shape_ok;
    bit          take;
    logic [31:0] tgt;
    shape_ok = (stall_EX == (pcsrc_EX != 2'b00));
    if (ex_valid && !shape_ok) m_err = 1;
    take = ex_valid && stall_EX && (pcsrc_EX != 2'b00) && (m_left == 0);
    if (m_left > 0) begin
      m_left--; m_instr = 0; m_valid = 0; m_flush = 0;
    end else if (take) begin
      case (pcsrc_EX)
        2'b01:   tgt = ex_pc_plus4 + 32'(int'($signed(ex_imm)) * 4);
        2'b10:   tgt = (ex_pc_plus4 & 32'hF000_0000) | (32'(ex_jindex) * 4);
        default: begin
          tgt = ex_jr_target & ~32'h3;
          if (ex_jr_target % 4 != 0) m_mis = 1;
        end
      endcase
      m_pc = tgt; m_instr = 0; m_valid = 0; m_flush = 1; m_left = BUBBLES;
      if (m_cnt < 65535) m_cnt++;
    end else if (!hold) begin
      m_instr = mem(m_pc); m_pp4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_flush = 0;
    end else begin
      m_flush = 0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    check("imem_addr",    imem_addr,          m_pc);
    check("id_instr",     id_instr,           m_instr);
    check("id_pc_plus4",  id_pc_plus4,        m_pp4);
    check("id_valid",     32'(id_valid),      32'(m_valid));
    check("flush",        32'(flush),         32'(m_flush));
    check("ctrl_err",     32'(ctrl_err),      32'(m_err));
    check("misalign",     32'(misalign),      32'(m_mis));
    check("redirect_cnt", 32'(redirect_cnt),  32'(m_cnt));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input bit v, input bit st, input logic [1:0] ps, input logic [31:0] pc4,
                       input logic [15:0] imm, input logic [25:0] ji, input logic [31:0] jr,
                       input bit hd);
    ex_valid = v; stall_EX = st; pcsrc_EX = ps; ex_pc_plus4 = pc4;
    ex_imm = imm; ex_jindex = ji; ex_jr_target = jr; hold = hd;
  endtask

  typedef struct {
    bit          v;
    bit          st;
    logic [1:0]  ps;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [25:0] ji;
    logic [31:0] jr;
    bit          hd;
    logic [31:0] e_pc;
    bit          e_fl;
    bit          e_err;
    bit          e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0004, 0, 0, 0, 16'd0};
    tbl[1]  = '{0, 1, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0008, 0, 0, 0, 16'd0};
    tbl[2]  = '{0, 0, 2'b10, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_000C, 0, 0, 0, 16'd0};
    tbl[3]  = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0010, 0, 0, 0, 16'd0};
    tbl[4]  = '{1, 1, 2'b01, 32'h20,        16'hFFFC, 26'h0,  32'h0,   0, 32'h0000_0010, 1, 0, 0, 16'd1};
    tbl[5]  = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0010, 0, 0, 0, 16'd1};
    tbl[6]  = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0014, 0, 0, 0, 16'd1};
    tbl[7]  = '{1, 1, 2'b10, 32'h4000_0010, 16'h0,    26'h10, 32'h0,   0, 32'h4000_0040, 1, 0, 0, 16'd2};
    tbl[8]  = '{1, 1, 2'b01, 32'h100,       16'h5,    26'h0,  32'h0,   0, 32'h4000_0040, 0, 0, 0, 16'd2};
    tbl[9]  = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h4000_0044, 0, 0, 0, 16'd2};
    tbl[10] = '{1, 1, 2'b11, 32'h0,         16'h0,    26'h0,  32'h103, 0, 32'h0000_0100, 1, 0, 1, 16'd3};
    tbl[11] = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0100, 0, 0, 1, 16'd3};
    tbl[12] = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   1, 32'h0000_0100, 0, 0, 1, 16'd3};
    tbl[13] = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   1, 32'h0000_0100, 0, 0, 1, 16'd3};
    tbl[14] = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   1, 32'h0000_0100, 0, 0, 1, 16'd3};
    tbl[15] = '{1, 1, 2'b01, 32'h200,       16'h4,    26'h0,  32'h0,   1, 32'h0000_0210, 1, 0, 1, 16'd4};
    tbl[16] = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   1, 32'h0000_0210, 0, 0, 1, 16'd4};
    tbl[17] = '{0, 0, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0214, 0, 0, 1, 16'd4};
    tbl[18] = '{1, 1, 2'b00, 32'h0,         16'h0,    26'h0,  32'h0,   0, 32'h0000_0218, 0, 1, 1, 16'd4};
    tbl[19] = '{1, 0, 2'b01, 32'h300,       16'h8,    26'h0,  32'h0,   0, 32'h0000_021C, 0, 1, 1, 16'd4};

    rst_n = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].ps, tbl[i].pc4, tbl[i].imm, tbl[i].ji, tbl[i].jr, tbl[i].hd);
      step();
      check($sformatf("tbl%0d_pc", i),    imem_addr,           tbl[i].e_pc);
      check($sformatf("tbl%0d_flush", i), 32'(flush),          32'(tbl[i].e_fl));
      check($sformatf("tbl%0d_err", i),   32'(ctrl_err),       32'(tbl[i].e_err));
      check($sformatf("tbl%0d_mis", i),   32'(misalign),       32'(tbl[i].e_mis));
      check($sformatf("tbl%0d_cnt", i),   32'(redirect_cnt),   32'(tbl[i].e_cnt));
    end

    // Asynchronous reset while a redirect's bubble is in flight.
    drive(1, 1, 2'b11, 0, 0, 0, 32'h80, 0);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check("rst_bubble_flush", 32'(flush), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_pc", imem_addr, 32'h4);
    check("post_rst_instr", id_instr, mem(32'h0));

    // Sequential fetch wrapping past the top of the address space.
    drive(1, 1, 2'b11, 0, 0, 0, 32'hFFFF_FFFC, 0);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    step();
    step();
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_pc4", id_pc_plus4, 32'h0);
    check("wrap_instr", id_instr, mem(32'hFFFF_FFFC));

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ps;
      bit         st;
      ps = 2'($urandom_range(0, 3));
      st = (ps != 2'b00);
      if ($urandom_range(0, 9) == 0) st = ~st;
      drive(($urandom_range(0, 3) != 0), st, ps, $urandom, 16'($urandom), 26'($urandom),
            $urandom, ($urandom_range(0, 4) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
